// File: rtl/hmi_pkg.sv
// Shared constants and types for the HMI key / frequency-setpoint front end.
// Key function indices, adjustment steps and the auto-repeat state encoding.
package hmi_pkg;

  localparam int KEY_UP1  = 0;
  localparam int KEY_DN1  = 1;
  localparam int KEY_UP10 = 2;
  localparam int KEY_DN10 = 3;
  localparam int KEY_DEF  = 4;

  localparam int STEP1  = 1;
  localparam int STEP10 = 10;

  localparam int TCNT_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } rpt_state_t;

  // Lowest set bit among the four repeatable keys; callers guarantee v != 0.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser (active-low in, active-high out) plus a tick-based
// stable-time counter; the debounced state only moves after DEB_US stable ticks.
module key_debounce #(
  parameter int DEB_US = 20000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic i_tick,
  input  logic i_key_n,
  output logic o_state
);

  localparam int CNT_W = (DEB_US > 1) ? $clog2(DEB_US) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sync;

  assign w_sync = ~r_sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (w_sync == r_state) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CNT_W'(DEB_US - 1)) begin
          r_state <= w_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/hmi_key_freq.sv
// HMI key front end: debounced key state, press / auto-repeat pulses, and a
// saturating frequency setpoint adjusted by keys 0..4 while sw is high.
module hmi_key_freq
  import hmi_pkg::*;
#(
  parameter int NKEY     = 8,
  parameter int FREQ_W   = 8,
  parameter int FREQ_MIN = 1,
  parameter int FREQ_MAX = 200,
  parameter int FREQ_RST = 50,
  parameter int DEB_US   = 20000,
  parameter int HOLD_US  = 500000,
  parameter int RPT_US   = 100000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic              sw,
  input  logic [NKEY-1:0]   key,
  output logic [NKEY-1:0]   key_state,
  output logic [NKEY-1:0]   key_press,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_upd
);

  localparam int SW_W = FREQ_W + 2;
  typedef logic signed [SW_W-1:0] sfreq_t;
  localparam sfreq_t L_MIN = sfreq_t'(FREQ_MIN);
  localparam sfreq_t L_MAX = sfreq_t'(FREQ_MAX);

  logic [NKEY-1:0]   w_state;
  logic [NKEY-1:0]   r_state_q;
  logic [NKEY-1:0]   w_rise;
  logic [NKEY-1:0]   r_press;
  logic [NKEY-1:0]   w_act;
  rpt_state_t        r_fsm;
  logic [1:0]        r_idx;
  logic [TCNT_W-1:0] r_tcnt;
  logic [FREQ_W-1:0] r_freq;
  logic              r_upd;
  logic              w_load;
  sfreq_t            w_delta;
  sfreq_t            w_sum;
  logic [FREQ_W-1:0] w_next;

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    key_debounce #(
      .DEB_US (DEB_US)
    ) u_deb (
      .clk_sys (clk_sys),
      .rst     (rst),
      .i_tick  (pluse_us),
      .i_key_n (key[g]),
      .o_state (w_state[g])
    );
  end

  assign w_rise = w_state & ~r_state_q;

  // Press pulses and the shared auto-repeat timer; a repeat pulse overrides
  // the edge-derived value for the tracked key only.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state_q <= '0;
      r_press   <= '0;
      r_fsm     <= IDLE;
      r_idx     <= '0;
      r_tcnt    <= '0;
    end else begin
      r_state_q <= w_state;
      r_press   <= w_rise;
      if (|w_rise[3:0]) begin
        r_idx  <= lowest_idx(w_rise[3:0]);
        r_tcnt <= '0;
        r_fsm  <= HOLD;
      end else if (r_fsm != IDLE && !w_state[r_idx]) begin
        r_tcnt <= '0;
        r_fsm  <= IDLE;
      end else if (pluse_us) begin
        case (r_fsm)
          HOLD: begin
            if (r_tcnt == TCNT_W'(HOLD_US - 1)) begin
              r_press[r_idx] <= 1'b1;
              r_tcnt         <= '0;
              r_fsm          <= RPT;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          RPT: begin
            if (r_tcnt == TCNT_W'(RPT_US - 1)) begin
              r_press[r_idx] <= 1'b1;
              r_tcnt         <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_act = r_press & {NKEY{sw}};

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_load  = 1'b0;
    w_delta = '0;
    if (w_act[KEY_DEF])       w_load  = 1'b1;
    else if (w_act[KEY_UP1])  w_delta = sfreq_t'(STEP1);
    else if (w_act[KEY_DN1])  w_delta = -sfreq_t'(STEP1);
    else if (w_act[KEY_UP10]) w_delta = sfreq_t'(STEP10);
    else if (w_act[KEY_DN10]) w_delta = -sfreq_t'(STEP10);

    // Two guard bits keep the sum from wrapping before the clamp.
    w_sum = $signed({2'b00, r_freq}) + w_delta;

    if (w_load)             w_next = FREQ_W'(FREQ_RST);
    else if (w_sum < L_MIN) w_next = FREQ_W'(FREQ_MIN);
    else if (w_sum > L_MAX) w_next = FREQ_W'(FREQ_MAX);
    else                    w_next = w_sum[FREQ_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_freq <= FREQ_W'(FREQ_RST);
      r_upd  <= 1'b0;
    end else begin
      r_upd  <= (w_next != r_freq);
      r_freq <= w_next;
    end
  end

  assign key_state = w_state;
  assign key_press = r_press;
  assign freq      = r_freq;
  assign freq_upd  = r_upd;

endmodule

// File: tb/tb_hmi_key_freq.sv
// Directed bench for hmi_key_freq: debounce, repeat timing, key priority,
// saturation, sw lock and reset, with hand-computed expectations.
module tb_hmi_key_freq;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pluse_us;
  logic       sw;
  logic [7:0] key;
  logic [7:0] key_state;
  logic [7:0] key_press;
  logic [7:0] freq;
  logic       freq_upd;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int press_cnt [8];
  int upd_cnt = 0;
  int t2 [$];

  hmi_key_freq #(
    .NKEY     (8),
    .FREQ_W   (8),
    .FREQ_MIN (1),
    .FREQ_MAX (60),
    .FREQ_RST (50),
    .DEB_US   (4),
    .HOLD_US  (10),
    .RPT_US   (5)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pluse_us  (pluse_us),
    .sw        (sw),
    .key       (key),
    .key_state (key_state),
    .key_press (key_press),
    .freq      (freq),
    .freq_upd  (freq_upd)
  );

  always #5 clk_sys = ~clk_sys;

  // 1 us tick: high for one cycle out of every two.
  initial begin
    pluse_us = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1 pluse_us = ~pluse_us;
    end
  end

  // Pulse monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      for (int i = 0; i < 8; i++) press_cnt[i] += int'(key_press[i]);
      if (key_press[2]) t2.push_back(cyc);
      upd_cnt += int'(freq_upd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) press_cnt[i] = 0;
    upd_cnt = 0;
    t2.delete();
  endtask

  task automatic wait_state(input int k, input logic v, input int budget);
    int n;
    n = 0;
    while (key_state[k] !== v && n < budget) begin
      tick_n(1);
      n++;
    end
    check($sformatf("wait_key_state%0d", k), 32'(key_state[k]), 32'(v));
  endtask

  task automatic press_key(input int k, input int hold);
    key[k] = 1'b0;
    tick_n(hold);
    key[k] = 1'b1;
    tick_n(30);
  endtask

  initial begin
    rst = 1'b1;
    sw  = 1'b1;
    key = 8'hFF;
    clear_counts();
    tick_n(3);
    rst = 1'b0;
    tick_n(1);

    // Reset values.
    check("rst_freq", 32'(freq), 32'd50);
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_key_press", 32'(key_press), 32'd0);
    check("rst_freq_upd", 32'(freq_upd), 32'd0);

    // Reset mid-hold aborts everything within one edge.
    key[0] = 1'b0;
    wait_state(0, 1'b1, 40);
    tick_n(3);
    check("hold_freq", 32'(freq), 32'd51);
    rst = 1'b1;
    key = 8'hFF;
    tick_n(1);
    check("midrst_freq", 32'(freq), 32'd50);
    check("midrst_key_state", 32'(key_state), 32'd0);
    check("midrst_key_press", 32'(key_press), 32'd0);
    check("midrst_freq_upd", 32'(freq_upd), 32'd0);
    tick_n(2);
    rst = 1'b0;
    clear_counts();
    tick_n(40);
    check("postrst_press", 32'(press_cnt[0]), 32'd0);
    check("postrst_upd", 32'(upd_cnt), 32'd0);
    check("postrst_freq", 32'(freq), 32'd50);

    // Bounce of 2 ticks is filtered; a 6-tick press counts once.
    key[0] = 1'b0;
    tick_n(4);
    key[0] = 1'b1;
    tick_n(20);
    check("bounce_state", 32'(key_state[0]), 32'd0);
    check("bounce_press", 32'(press_cnt[0]), 32'd0);
    key[0] = 1'b0;
    tick_n(12);
    key[0] = 1'b1;
    tick_n(30);
    check("k0_press", 32'(press_cnt[0]), 32'd1);
    check("k0_freq", 32'(freq), 32'd51);
    check("k0_upd", 32'(upd_cnt), 32'd1);
    check("k0_released", 32'(key_state[0]), 32'd0);

    // Hold key 2: first repeat 19 cycles after the press pulse, then every 10.
    clear_counts();
    key[2] = 1'b0;
    tick_n(80);
    key[2] = 1'b1;
    tick_n(40);
    check("rpt_count_ge3", 32'(t2.size() >= 3), 32'd1);
    if (t2.size() >= 3) begin
      check("rpt_hold_gap", 32'(t2[1] - t2[0]), 32'd19);
      check("rpt_rpt_gap", 32'(t2[2] - t2[1]), 32'd10);
    end
    check("rpt_freq_sat", 32'(freq), 32'd60);
    check("rpt_upd_once", 32'(upd_cnt), 32'd1);

    // sw=0: press still reported, freq frozen.
    sw = 1'b0;
    clear_counts();
    press_key(1, 14);
    check("lock_press", 32'(press_cnt[1]), 32'd1);
    check("lock_freq", 32'(freq), 32'd60);
    check("lock_upd", 32'(upd_cnt), 32'd0);
    sw = 1'b1;

    // Key 4 loads the default.
    clear_counts();
    press_key(4, 14);
    check("def_freq", 32'(freq), 32'd50);
    check("def_upd", 32'(upd_cnt), 32'd1);

    // Key 4 beats key 0 in the same cycle: load 50 over 50 is a no-op.
    clear_counts();
    key[0] = 1'b0;
    key[4] = 1'b0;
    tick_n(14);
    key[0] = 1'b1;
    key[4] = 1'b1;
    tick_n(30);
    check("prio_k4_freq", 32'(freq), 32'd50);
    check("prio_k4_upd", 32'(upd_cnt), 32'd0);
    check("prio_k0_press", 32'(press_cnt[0]), 32'd1);

    // Keys 0 and 1 together: +1 only; FSM tracks key 0, so no repeats on key 1.
    clear_counts();
    key[0] = 1'b0;
    key[1] = 1'b0;
    wait_state(0, 1'b1, 40);
    check("dual_state1", 32'(key_state[1]), 32'd1);
    key[0] = 1'b1;
    tick_n(60);
    key[1] = 1'b1;
    tick_n(30);
    check("dual_press0", 32'(press_cnt[0]), 32'd1);
    check("dual_press1", 32'(press_cnt[1]), 32'd1);
    check("dual_freq", 32'(freq), 32'd51);
    check("dual_upd", 32'(upd_cnt), 32'd1);

    // Walk down to FREQ_MIN, then saturate there.
    repeat (5) press_key(3, 14);
    check("down_freq", 32'(freq), 32'd1);
    clear_counts();
    press_key(3, 14);
    check("min_dn10_freq", 32'(freq), 32'd1);
    check("min_dn10_upd", 32'(upd_cnt), 32'd0);
    check("min_dn10_press", 32'(press_cnt[3]), 32'd1);
    press_key(1, 14);
    check("min_dn1_freq", 32'(freq), 32'd1);
    check("min_dn1_upd", 32'(upd_cnt), 32'd0);
    press_key(4, 14);
    check("min_def_freq", 32'(freq), 32'd50);
    check("min_def_upd", 32'(upd_cnt), 32'd1);

    // Key 5 is report-only.
    clear_counts();
    press_key(5, 14);
    check("k5_press", 32'(press_cnt[5]), 32'd1);
    check("k5_freq", 32'(freq), 32'd50);
    check("k5_upd", 32'(upd_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
